// File: rtl/snake_pkg.sv
// Shared encodings for the snake step engine: directions, FSM states and grid cells.
package snake_pkg;
    localparam int GX_W = 6;
    localparam int GY_W = 5;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CALC,
        ST_SCAN,
        ST_ERASE,
        ST_DRAW,
        ST_OVER
    } state_t;

    typedef struct packed {
        logic [GX_W-1:0] gx;
        logic [GY_W-1:0] gy;
    } cell_t;

    // Opposite directions are bitwise complements, so a reversal is req == ~cur.
    function automatic logic is_reversal(dir_t req, dir_t cur);
        return req == dir_t'(~cur);
    endfunction
endpackage

// File: rtl/snake_step_engine_cell_raster.sv
// CELL x CELL pixel walker, row-major with cx fastest; runs while start is held high.
module cell_raster #(
    parameter  int CELL = 4,
    localparam int CW   = (CELL > 1) ? $clog2(CELL) : 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic          done
);
    logic last;

    assign last = (cx == CW'(CELL - 1)) && (cy == CW'(CELL - 1));
    assign done = start && last;

    always_ff @(posedge Clock) begin
        if (Reset || !start) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == CW'(CELL - 1)) begin
            cx <= '0;
            cy <= last ? '0 : cy + 1'b1;
        end else begin
            cx <= cx + 1'b1;
        end
    end
endmodule

// File: rtl/snake_step_engine.sv
// Snake body held in a circular position buffer; each tick moves it one cell and
// streams erase-tail / draw-head pixels to the VGA adapter.
module snake_step_engine
    import snake_pkg::*;
#(
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int CELL    = 4,
    parameter int MAXLEN  = 16,
    parameter int INITLEN = 3,
    parameter int X0      = 10,
    parameter int Y0      = 7
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  logic [2:0] head_colour,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       ate,
    output logic       game_over,
    output logic [6:0] length
);
    localparam int GW = XSCREEN / CELL;
    localparam int GH = YSCREEN / CELL;
    localparam int PW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;

    state_t        state, state_n;
    dir_t          cur_dir, next_dir;
    cell_t         body [MAXLEN];
    logic [PW-1:0] hp;
    logic [6:0]    init_seg, scan_idx;
    cell_t         new_head, tail_cell;
    logic          grow, apple_hit;

    cell_t         head_cell, calc_head, scan_cell, raster_cell, apple_cell, commit_cell;
    logic          wall, calc_hit, calc_grow, skip_scan, scan_match, scan_last, commit;
    logic          raster_on, raster_done;
    logic [CW-1:0] cx, cy;

    assign apple_cell  = '{gx: apple_x, gy: apple_y};
    assign head_cell   = body[hp];
    assign scan_cell   = body[hp - scan_idx[PW-1:0]];
    assign calc_hit    = (calc_head == apple_cell);
    assign calc_grow   = calc_hit && (length < 7'(MAXLEN));
    assign skip_scan   = !calc_grow && (length == 7'd1);
    assign scan_match  = (scan_cell == new_head);
    assign scan_last   = grow ? (scan_idx == length - 7'd1) : (scan_idx == length - 7'd2);
    assign commit_cell = (state == ST_CALC) ? calc_head : new_head;
    assign raster_on   = (state == ST_INIT) || (state == ST_ERASE) || (state == ST_DRAW);
    assign busy        = (state != ST_IDLE) && (state != ST_OVER);
    assign game_over   = (state == ST_OVER);

    // Direction of this step is next_dir, the value being copied into cur_dir in CALC.
    always_comb begin
        calc_head = head_cell;
        wall      = 1'b0;
        case (next_dir)
            DIR_RIGHT: begin
                wall         = (head_cell.gx == GX_W'(GW - 1));
                calc_head.gx = head_cell.gx + 1'b1;
            end
            DIR_LEFT: begin
                wall         = (head_cell.gx == '0);
                calc_head.gx = head_cell.gx - 1'b1;
            end
            DIR_DOWN: begin
                wall         = (head_cell.gy == GY_W'(GH - 1));
                calc_head.gy = head_cell.gy + 1'b1;
            end
            DIR_UP: begin
                wall         = (head_cell.gy == '0);
                calc_head.gy = head_cell.gy - 1'b1;
            end
        endcase
    end

    always_comb begin
        case (state)
            ST_INIT:  raster_cell = '{gx: GX_W'(X0) - init_seg[GX_W-1:0], gy: GY_W'(Y0)};
            ST_ERASE: raster_cell = tail_cell;
            default:  raster_cell = new_head;
        endcase
    end

    // A single-cell body has nothing to scan, so the head is committed straight from CALC.
    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            ST_INIT:  if (raster_done && init_seg == 7'(INITLEN - 1)) state_n = ST_IDLE;
            ST_IDLE:  if (tick) state_n = ST_CALC;
            ST_CALC: begin
                if (wall) begin
                    state_n = ST_OVER;
                end else if (skip_scan) begin
                    commit  = 1'b1;
                    state_n = ST_ERASE;
                end else begin
                    state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_match) begin
                    state_n = ST_OVER;
                end else if (scan_last) begin
                    commit  = 1'b1;
                    state_n = grow ? ST_DRAW : ST_ERASE;
                end
            end
            ST_ERASE: if (raster_done) state_n = ST_DRAW;
            ST_DRAW:  if (raster_done) state_n = ST_IDLE;
            ST_OVER:  state_n = ST_OVER;
            default:  state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_INIT;
            cur_dir   <= DIR_RIGHT;
            next_dir  <= DIR_RIGHT;
            hp        <= PW'(INITLEN - 1);
            length    <= 7'(INITLEN);
            init_seg  <= '0;
            scan_idx  <= '0;
            new_head  <= '0;
            tail_cell <= '0;
            grow      <= 1'b0;
            apple_hit <= 1'b0;
            plot      <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            ate       <= 1'b0;
            for (int i = 0; i < INITLEN; i++) begin
                body[PW'(INITLEN - 1 - i)] <= '{gx: GX_W'(X0 - i), gy: GY_W'(Y0)};
            end
        end else begin
            state <= state_n;
            if (dir_valid && !is_reversal(dir_t'(dir_req), cur_dir)) begin
                next_dir <= dir_t'(dir_req);
            end
            if (state == ST_INIT && raster_done) begin
                init_seg <= init_seg + 7'd1;
            end
            if (state == ST_CALC) begin
                cur_dir   <= next_dir;
                new_head  <= calc_head;
                grow      <= calc_grow;
                apple_hit <= calc_hit;
                tail_cell <= body[hp - PW'(length - 7'd1)];
            end
            scan_idx <= (state == ST_SCAN) ? scan_idx + 7'd1 : 7'd0;
            if (commit) begin
                hp                <= hp + 1'b1;
                body[hp + 1'b1]   <= commit_cell;
            end
            if (commit && state == ST_SCAN && grow) begin
                length <= length + 7'd1;
            end
            plot   <= raster_on;
            x      <= 8'(int'(raster_cell.gx) * CELL + int'(cx));
            y      <= 7'(int'(raster_cell.gy) * CELL + int'(cy));
            colour <= (state == ST_ERASE) ? 3'b000 : head_colour;
            ate    <= (state == ST_DRAW) && raster_done && apple_hit;
        end
    end

    cell_raster #(.CELL(CELL)) u_raster (
        .Clock (Clock),
        .Reset (Reset),
        .start (raster_on),
        .cx    (cx),
        .cy    (cy),
        .done  (raster_done)
    );
endmodule

// File: tb/tb_snake_step_engine.sv
// Directed bench: default engine (main) plus a MAXLEN=4 copy for the full-length apple case.
module tb_snake_step_engine;
    localparam logic [1:0] D_RIGHT = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_UP    = 2'b10;
    localparam logic [1:0] D_LEFT  = 2'b11;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       tick_a = 1'b0, tick_b = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic [2:0] head_colour = 3'b010;
    logic [5:0] apple_x = 6'd0;
    logic [4:0] apple_y = 5'd0;
    logic       sel = 1'b0;

    logic [7:0] x_a, x_b;
    logic [6:0] y_a, y_b, len_a, len_b;
    logic [2:0] colour_a, colour_b;
    logic       plot_a, plot_b, busy_a, busy_b, ate_a, ate_b, over_a, over_b;

    logic [7:0] o_x;
    logic [6:0] o_y, o_len;
    logic [2:0] o_colour;
    logic       o_plot, o_busy, o_ate, o_over;

    int n_checks = 0;
    int n_fail   = 0;
    int st_busy, st_erase, st_draw, st_ate, st_done;
    int er_xmin, er_xmax, er_ymin, er_ymax, dr_xmin, dr_xmax, dr_ymin, dr_ymax;
    int first_x, first_y;

    always #5 Clock = ~Clock;

    snake_step_engine dut_a (
        .Clock(Clock), .Reset(Reset), .tick(tick_a), .dir_valid(dir_valid), .dir_req(dir_req),
        .head_colour(head_colour), .apple_x(apple_x), .apple_y(apple_y),
        .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a), .busy(busy_a),
        .ate(ate_a), .game_over(over_a), .length(len_a)
    );

    snake_step_engine #(.MAXLEN(4)) dut_b (
        .Clock(Clock), .Reset(Reset), .tick(tick_b), .dir_valid(dir_valid), .dir_req(dir_req),
        .head_colour(head_colour), .apple_x(apple_x), .apple_y(apple_y),
        .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b), .busy(busy_b),
        .ate(ate_b), .game_over(over_b), .length(len_b)
    );

    assign o_x      = sel ? x_b      : x_a;
    assign o_y      = sel ? y_b      : y_a;
    assign o_len    = sel ? len_b    : len_a;
    assign o_colour = sel ? colour_b : colour_a;
    assign o_plot   = sel ? plot_b   : plot_a;
    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_ate    = sel ? ate_b    : ate_a;
    assign o_over   = sel ? over_b   : over_a;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Samples one negedge per cycle until busy drops, classifying plotted pixels by colour.
    task automatic collect(input logic extra_tick);
        st_busy = 0; st_erase = 0; st_draw = 0; st_ate = 0; st_done = 0;
        er_xmin = 999; er_xmax = -1; er_ymin = 999; er_ymax = -1;
        dr_xmin = 999; dr_xmax = -1; dr_ymin = 999; dr_ymax = -1;
        first_x = -1; first_y = -1;
        for (int c = 0; c < 400; c++) begin
            if (extra_tick) begin
                if (sel) tick_b = (c == 5);
                else     tick_a = (c == 5);
            end
            if (o_plot === 1'b1) begin
                if (first_x < 0) begin
                    first_x = int'(o_x);
                    first_y = int'(o_y);
                end
                if (o_colour === 3'b000) begin
                    st_erase++;
                    if (int'(o_x) < er_xmin) er_xmin = int'(o_x);
                    if (int'(o_x) > er_xmax) er_xmax = int'(o_x);
                    if (int'(o_y) < er_ymin) er_ymin = int'(o_y);
                    if (int'(o_y) > er_ymax) er_ymax = int'(o_y);
                end else begin
                    st_draw++;
                    if (int'(o_x) < dr_xmin) dr_xmin = int'(o_x);
                    if (int'(o_x) > dr_xmax) dr_xmax = int'(o_x);
                    if (int'(o_y) < dr_ymin) dr_ymin = int'(o_y);
                    if (int'(o_y) > dr_ymax) dr_ymax = int'(o_y);
                end
            end
            if (o_ate === 1'b1) st_ate++;
            if (o_busy !== 1'b1) begin
                st_done = 1;
                break;
            end
            st_busy++;
            @(negedge Clock);
        end
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    task automatic applyStimulus(input logic dv, input logic [1:0] dr, input logic extra_tick);
        dir_valid = dv;
        dir_req   = dr;
        if (sel) tick_b = 1'b1;
        else     tick_a = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        dir_valid = 1'b0;
        tick_a    = 1'b0;
        tick_b    = 1'b0;
        collect(extra_tick);
        checkOutput("step_done", st_done, 1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge Clock);
        checkOutput("rst_plot", o_plot, 0);
        checkOutput("rst_x", o_x, 0);
        checkOutput("rst_y", o_y, 0);
        checkOutput("rst_colour", o_colour, 0);
        checkOutput("rst_ate", o_ate, 0);
        checkOutput("rst_over", o_over, 0);
        checkOutput("rst_length", o_len, 3);
        checkOutput("rst_busy", o_busy, 1);

        // INIT draws (10,7),(9,7),(8,7) head first
        Reset = 1'b0;
        @(negedge Clock);
        collect(1'b0);
        checkOutput("init_done", st_done, 1);
        checkOutput("init_plots", st_draw + st_erase, 48);
        checkOutput("init_xmin", dr_xmin, 32);
        checkOutput("init_xmax", dr_xmax, 43);
        checkOutput("init_ymin", dr_ymin, 28);
        checkOutput("init_ymax", dr_ymax, 31);
        checkOutput("init_first_x", first_x, 40);
        checkOutput("init_first_y", first_y, 28);
        checkOutput("init_length", o_len, 3);

        // MAXLEN=4 copy: grow to 4, then eat again at full length
        sel = 1'b1;
        apple_x = 6'd11; apple_y = 5'd7;
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("b_grow_busy", st_busy, 20);
        checkOutput("b_grow_erase", st_erase, 0);
        checkOutput("b_grow_draw", st_draw, 16);
        checkOutput("b_grow_ate", st_ate, 1);
        checkOutput("b_grow_len", o_len, 4);
        apple_x = 6'd12; apple_y = 5'd7;
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("b_full_busy", st_busy, 36);
        checkOutput("b_full_erase", st_erase, 16);
        checkOutput("b_full_er_xmin", er_xmin, 32);
        checkOutput("b_full_ate", st_ate, 1);
        checkOutput("b_full_len", o_len, 4);
        sel = 1'b0;
        apple_x = 6'd0; apple_y = 5'd0;

        // Plain step: (10,7) -> (11,7), tail (8,7) erased
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("s1_busy", st_busy, 35);
        checkOutput("s1_erase", st_erase, 16);
        checkOutput("s1_er_xmin", er_xmin, 32);
        checkOutput("s1_er_xmax", er_xmax, 35);
        checkOutput("s1_er_ymin", er_ymin, 28);
        checkOutput("s1_draw", st_draw, 16);
        checkOutput("s1_dr_xmin", dr_xmin, 44);
        checkOutput("s1_dr_xmax", dr_xmax, 47);
        checkOutput("s1_dr_ymax", dr_ymax, 31);
        checkOutput("s1_ate", st_ate, 0);
        checkOutput("s1_length", o_len, 3);

        // LEFT is a reversal: head still goes to (12,7); a mid-step tick is dropped
        applyStimulus(1'b1, D_LEFT, 1'b1);
        checkOutput("s2_dr_xmin", dr_xmin, 48);
        checkOutput("s2_dr_ymin", dr_ymin, 28);
        checkOutput("s2_er_xmin", er_xmin, 36);
        repeat (3) @(negedge Clock);
        checkOutput("s2_tick_dropped", o_busy, 0);

        // UP with the tick: (12,7) -> (12,6)
        applyStimulus(1'b1, D_UP, 1'b0);
        checkOutput("s3_dr_xmin", dr_xmin, 48);
        checkOutput("s3_dr_ymin", dr_ymin, 24);
        checkOutput("s3_dr_ymax", dr_ymax, 27);
        checkOutput("s3_er_xmin", er_xmin, 40);

        // Apple at (13,6): growth to 4, no erase
        apple_x = 6'd13; apple_y = 5'd6;
        applyStimulus(1'b1, D_RIGHT, 1'b0);
        checkOutput("ap_busy", st_busy, 20);
        checkOutput("ap_erase", st_erase, 0);
        checkOutput("ap_ate", st_ate, 1);
        checkOutput("ap_length", o_len, 4);
        checkOutput("ap_dr_xmin", dr_xmin, 52);
        apple_x = 6'd0; apple_y = 5'd0;

        // Length-4 loop; the head twice lands on the vacating tail
        applyStimulus(1'b1, D_DOWN, 1'b0);
        checkOutput("lp_d_busy", st_busy, 36);
        checkOutput("lp_d_er_xmin", er_xmin, 44);
        checkOutput("lp_d_dr_ymin", dr_ymin, 28);
        applyStimulus(1'b1, D_LEFT, 1'b0);
        checkOutput("lp_l_over", o_over, 0);
        checkOutput("lp_l_busy", st_busy, 36);
        checkOutput("lp_l_dr_xmin", dr_xmin, 48);
        applyStimulus(1'b1, D_UP, 1'b0);
        checkOutput("lp_u_over", o_over, 0);
        checkOutput("lp_u_dr_ymin", dr_ymin, 24);
        checkOutput("lp_u_er_ymin", er_ymin, 24);

        // Grow to 5 at (12,5), then RIGHT, DOWN, LEFT bites segment 3
        apple_x = 6'd12; apple_y = 5'd5;
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("g5_length", o_len, 5);
        checkOutput("g5_dr_ymin", dr_ymin, 20);
        apple_x = 6'd0; apple_y = 5'd0;
        applyStimulus(1'b1, D_RIGHT, 1'b0);
        applyStimulus(1'b1, D_DOWN, 1'b0);
        checkOutput("sc_pre_over", o_over, 0);
        applyStimulus(1'b1, D_LEFT, 1'b0);
        checkOutput("sc_over", o_over, 1);
        checkOutput("sc_busy", st_busy, 5);
        checkOutput("sc_plots", st_erase + st_draw, 0);
        checkOutput("sc_length", o_len, 5);
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("sc_tick_ignored", st_busy, 0);
        checkOutput("sc_still_over", o_over, 1);

        // Reset from OVER, then reset again in the middle of an erase
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("rs_over_clear", o_over, 0);
        checkOutput("rs_busy", o_busy, 1);
        Reset = 1'b0;
        @(negedge Clock);
        collect(1'b0);
        checkOutput("rs_init_done", st_done, 1);
        tick_a = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        tick_a = 1'b0;
        repeat (11) @(negedge Clock);
        checkOutput("mid_plot", o_plot, 1);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("mid_rst_plot", o_plot, 0);
        checkOutput("mid_rst_busy", o_busy, 1);
        checkOutput("mid_rst_len", o_len, 3);
        Reset = 1'b0;
        @(negedge Clock);
        collect(1'b0);
        checkOutput("rs2_init_done", st_done, 1);

        // Walk right to gx=39, then the wall
        for (int s = 0; s < 29; s++) applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("edge_dr_xmax", dr_xmax, 159);
        checkOutput("edge_over", o_over, 0);
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("wall_busy", st_busy, 1);
        checkOutput("wall_plots", st_erase + st_draw, 0);
        checkOutput("wall_over", o_over, 1);
        applyStimulus(1'b0, D_RIGHT, 1'b0);
        checkOutput("wall_tick_ignored", st_busy, 0);
        checkOutput("wall_still_over", o_over, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
